sign_stim_gen: RTL and testbench

SIGN_STIM_GEN -- requirements
Module: sign_stim_gen

---
 rtl/sign_pkg.sv | 56 +++++
 rtl/sign_lfsr16.sv | 40 ++++
 rtl/sign_stim_gen.sv | 144 ++++++++++++++
 tb/tb_sign_stim_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_pkg.sv
`timescale 1ns/1ps
// sign_pkg: shared types, constants and small helpers for the sign stimulus generator.
package sign_pkg;

  // Width of generated values and of the per-class counters.
  localparam int DATA_W = 16;

  // Galois LFSR reset value and feedback taps (applied after a right shift).
  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

  // Saturation ceiling of the per-class counters.
  localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};

  // Smallest positive value, used when a POS draw would otherwise be zero.
  localparam logic [DATA_W-1:0] ONE_VAL = {{(DATA_W-1){1'b0}}, 1'b1};

  // Requested sign class, encoded as on the request interface.
  typedef enum logic [1:0] {
    ZERO = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10,
    RSVD = 2'b11
  } sign_class_e;

  // Controller state.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sign_state_e;

  // Map an LFSR state onto a value of the requested sign class.
  // POS forces the MSB low and never yields zero; NEG forces the MSB high.
  function automatic logic [DATA_W-1:0] map_value(input sign_class_e cls,
                                                   input logic [DATA_W-1:0] l);
    logic [DATA_W-1:0] v;
    v = '0;
    case (cls)
      POS: begin
        v = {1'b0, l[DATA_W-2:0]};
        if (v == '0) begin
          v = ONE_VAL;
        end
      end
      NEG:     v = {1'b1, l[DATA_W-2:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + ONE_VAL);
  endfunction

endpackage

// File: rtl/sign_lfsr16.sv
`timescale 1ns/1ps
// sign_lfsr16: 16-bit right-shifting Galois LFSR that steps only when advance is high.
module sign_lfsr16
  import sign_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_reg;
  logic [15:0] state_next;

  genvar gi;

  // Feedback network: each bit takes its left neighbour, XORed with the
  // pre-shift LSB wherever the tap mask has a one. Bit 15 shifts in zero.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      if (gi == 15) begin : g_top
        assign state_next[gi] = state_reg[0] & LFSR_TAPS[gi];
      end else begin : g_mid
        assign state_next[gi] = state_reg[gi+1] ^ (state_reg[0] & LFSR_TAPS[gi]);
      end
    end
  endgenerate

  // State register: reloads the seed on reset, steps once per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LFSR_SEED;
    end else if (advance) begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/sign_stim_gen.sv
`timescale 1ns/1ps
// sign_stim_gen: emits a requested number of zero, positive or negative
// pseudo-random values over a valid/ready stream and keeps per-class counts.
module sign_stim_gen
  import sign_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_class,
  input  logic [7:0]  req_count,
  output logic        req_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        err,
  output logic [15:0] pos_cnt,
  output logic [15:0] neg_cnt,
  output logic [15:0] zero_cnt
);

  sign_state_e       state_reg, state_next;
  sign_class_e       cls_reg, cls_next;
  logic [7:0]        remain_reg, remain_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  sign_class_e       req_cls;
  logic              accept;
  logic              xfer;
  logic [DATA_W-1:0] lfsr_state;
  logic [DATA_W-1:0] cnt_val [3];

  genvar gi;

  assign req_cls = sign_class_e'(req_class);
  assign accept  = req_valid && req_ready;
  assign xfer    = out_valid && out_ready;

  // Value source; it only moves when a value is actually handed downstream,
  // so a stalled output keeps presenting the same data.
  sign_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (xfer),
    .state   (lfsr_state)
  );

  // State register: controller state, held request and the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cls_reg    <= ZERO;
      remain_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cls_reg    <= cls_next;
      remain_reg <= remain_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // Next-state logic: accept in IDLE, count transfers down in EMIT.
  // Empty and reserved requests complete from IDLE without emitting.
  always_comb begin
    state_next  = state_reg;
    cls_next    = cls_reg;
    remain_next = remain_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_cls == RSVD) begin
            err_next = 1'b1;
          end else if (req_count == 8'd0) begin
            done_next = 1'b1;
          end else begin
            state_next  = EMIT;
            cls_next    = req_cls;
            remain_next = req_count;
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          remain_next = remain_reg - 8'd1;
          if (remain_reg == 8'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: handshake flags follow the state; data is the class mapping
  // of the current LFSR state while emitting, zero otherwise.
  always_comb begin
    req_ready = (state_reg == IDLE);
    out_valid = (state_reg == EMIT);
    out_data  = '0;
    if (state_reg == EMIT) begin
      out_data = map_value(cls_reg, lfsr_state);
    end
  end

  assign done = done_reg;
  assign err  = err_reg;

  // One saturating counter per emitting class, indexed by the class code.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      localparam logic [1:0] CLS_CODE = 2'(gi);
      logic [DATA_W-1:0] cnt_reg;
      logic              hit;

      assign hit = xfer && (cls_reg == sign_class_e'(CLS_CODE));

      // Count transfers of this class, sticking at the ceiling.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (hit) begin
          cnt_reg <= sat_inc(cnt_reg);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign zero_cnt = cnt_val[0];
  assign pos_cnt  = cnt_val[1];
  assign neg_cnt  = cnt_val[2];

endmodule

// File: tb/tb_sign_stim_gen.sv
`timescale 1ns/1ps
// tb_sign_stim_gen: directed scoreboard bench for sign_stim_gen.
module tb_sign_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_class = 2'b00;
  logic [7:0]  req_count = 8'd0;
  logic        req_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic        done;
  logic        err;
  logic [15:0] pos_cnt;
  logic [15:0] neg_cnt;
  logic [15:0] zero_cnt;

  sign_stim_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_class (req_class),
    .req_count (req_count),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done),
    .err       (err),
    .pos_cnt   (pos_cnt),
    .neg_cnt   (neg_cnt),
    .zero_cnt  (zero_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] lfsr_m = 16'hACE1;
  int          cyc = 0;
  int          xfer_tally = 0;
  int          done_tally = 0;
  int          err_tally = 0;
  int          last_xfer_cyc = -1;
  int          last_done_cyc = -1;

  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;
  logic [15:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every transfer and watches the pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          errors++;
          $display("FAIL hold actual valid=%b data=%h required valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer actual data=%h required no transfer", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_data !== mon_exp) begin
            errors++;
            $display("FAIL xfer_data actual=%h required=%h", out_data, mon_exp);
          end
        end
        xfer_tally++;
        last_xfer_cyc = cyc;
      end
      if (done || err) begin
        checks++;
        if ((done && err) || (done && prev_done) || (err && prev_err)) begin
          errors++;
          $display("FAIL pulse actual done=%b err=%b prev_done=%b prev_err=%b required single exclusive pulse",
                   done, err, prev_done, prev_err);
        end
      end
      if (done) begin
        done_tally++;
        last_done_cyc = cyc;
      end
      if (err) err_tally++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_done = done;
      prev_err  = err;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Expected values for cnt transfers of class cls, advancing the bench LFSR.
  task automatic push_exp(input logic [1:0] cls, input int cnt);
    logic [15:0] v;
    for (int i = 0; i < cnt; i++) begin
      case (cls)
        2'b01: begin
          v = {1'b0, lfsr_m[14:0]};
          if (v == 16'h0000) v = 16'h0001;
        end
        2'b10:   v = {1'b1, lfsr_m[14:0]};
        default: v = 16'h0000;
      endcase
      exp_q.push_back(v);
      lfsr_m = lfsr_step(lfsr_m);
    end
  endtask

  task automatic send_req(input logic [1:0] cls, input logic [7:0] cnt);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    req_valid = 1'b1;
    req_class = cls;
    req_count = cnt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_evt(input bit want_err, input int budget, input string name);
    int base;
    base = want_err ? err_tally : done_tally;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if ((want_err ? err_tally : done_tally) != base) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=pulse within %0d cycles", name, budget);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_class = 2'b00;
    req_count = 8'd0;
    out_ready = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    lfsr_m = 16'hACE1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x, base_d, base_e, rem, n;
    logic [15:0] p0, n0, z0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_counters", {pos_cnt, neg_cnt, zero_cnt}, 0);
    do_reset();

    // POS count 2, ready held high
    exp_q.push_back(16'h2CE1);
    exp_q.push_back(16'h6270);
    send_req(2'b01, 8'd2);
    wait_evt(0, 20, "v1_done");
    chk("v1_done_latency", last_done_cyc, last_xfer_cyc + 1);
    chk("v1_pos_cnt", pos_cnt, 2);
    chk("v1_idle_valid", out_valid, 0);

    // NEG count 1, stalled 5 cycles, request inputs wiggled meanwhile
    do_reset();
    base_x = xfer_tally;
    base_e = err_tally;
    out_ready = 1'b0;
    exp_q.push_back(16'hACE1);
    send_req(2'b10, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("v2_stall_valid", out_valid, 1);
      chk("v2_stall_data", out_data, 16'hACE1);
      req_valid = 1'b1;
      req_class = 2'b11;
      req_count = 8'd7;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    wait_evt(0, 20, "v2_done");
    chk("v2_neg_cnt", neg_cnt, 1);
    chk("v2_one_xfer", xfer_tally, base_x + 1);
    chk("v2_no_err", err_tally, base_e);
    exp_q.push_back(16'h6270);
    send_req(2'b01, 8'd1);
    wait_evt(0, 20, "v2b_done");
    chk("v2b_pos_cnt", pos_cnt, 1);

    // ZERO count 3, then reserved class
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    send_req(2'b00, 8'd3);
    wait_evt(0, 20, "v3_done");
    chk("v3_zero_cnt", zero_cnt, 3);
    base_d = done_tally;
    base_x = xfer_tally;
    p0 = pos_cnt; n0 = neg_cnt; z0 = zero_cnt;
    send_req(2'b11, 8'd5);
    wait_evt(1, 5, "v3_err");
    repeat (3) tick();
    chk("v3_err_no_done", done_tally, base_d);
    chk("v3_err_no_xfer", xfer_tally, base_x);
    chk("v3_err_counters", {pos_cnt, neg_cnt, zero_cnt}, {p0, n0, z0});

    // POS count 0
    base_x = xfer_tally;
    p0 = pos_cnt;
    send_req(2'b01, 8'd0);
    @(negedge clk);
    chk("v4_done_next", done, 1);
    chk("v4_no_valid", out_valid, 0);
    repeat (3) tick();
    chk("v4_no_xfer", xfer_tally, base_x);
    chk("v4_pos_cnt", pos_cnt, p0);

    // Reset in the middle of POS count 10
    do_reset();
    base_x = xfer_tally;
    push_exp(2'b01, 10);
    send_req(2'b01, 8'd10);
    n = 0;
    while (xfer_tally < base_x + 4 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    tick();
    chk("v5_pos_before_rst", pos_cnt, 4);
    base_d = done_tally;
    rst_n = 1'b0;
    #1;
    chk("v5_rst_valid", out_valid, 0);
    chk("v5_rst_pos_cnt", pos_cnt, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("v5_no_done", done_tally, base_d);
    chk("v5_xfers", xfer_tally, base_x + 4);
    lfsr_m = 16'hACE1;
    exp_q.push_back(16'h2CE1);
    send_req(2'b01, 8'd1);
    wait_evt(0, 20, "v5_done");
    chk("v5_pos_after", pos_cnt, 1);

    // Saturation of pos_cnt
    do_reset();
    rem = 65534;
    while (rem > 0) begin
      n = (rem > 255) ? 255 : rem;
      push_exp(2'b01, n);
      send_req(2'b01, n[7:0]);
      wait_evt(0, 400, "v6_bulk_done");
      rem -= n;
    end
    chk("v6_pos_fffe", pos_cnt, 16'hFFFE);
    push_exp(2'b01, 3);
    send_req(2'b01, 8'd3);
    wait_evt(0, 20, "v6_done");
    chk("v6_pos_sat", pos_cnt, 16'hFFFF);
    push_exp(2'b01, 2);
    send_req(2'b01, 8'd2);
    wait_evt(0, 20, "v6b_done");
    chk("v6_pos_stay", pos_cnt, 16'hFFFF);
    chk("v6_other_cnt", {neg_cnt, zero_cnt}, 0);

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
